multi_tick_divider: RTL and testbench

- N-channel programmable tick divider: successor to the fixed single-channel divider, with a runtime divisor, enable and square-wave output per channel.
- Each channel counts strobes on a shared tick_in (e.g. a 1 kHz prescaler tick) and emits a one-clk pulse every DIV strobes, plus a toggling square wave of period 2×DIV strobes.
- Sits between the board-clock prescaler and LED/PWM/debounce timing consumers.

---
 rtl/multi_tick_divider_pkg.sv | 17 +
 rtl/multi_tick_divider_channel.sv | 75 +++++++
 rtl/multi_tick_divider.sv | 54 +++++
 tb/tb_multi_tick_divider.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/multi_tick_divider_pkg.sv
// rtl/multi_tick_divider_pkg.sv - shared defaults, types and index-width helper for multi_tick_divider
package multi_tick_divider_pkg;

  localparam int DEF_WIDTH    = 22;
  localparam int DEF_DIV      = 3300000;
  localparam int DEF_CHANNELS = 4;

  typedef logic [DEF_WIDTH-1:0] div_t;

  // A single-channel build still needs a 1-bit channel select.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  typedef logic [idx_width(DEF_CHANNELS)-1:0] ch_idx_t;

endpackage

// File: rtl/multi_tick_divider_channel.sv
// rtl/multi_tick_divider_channel.sv - one divider channel: counter, divisor/enable, pulse and square outputs
// Global clear input i_sync exists only when MULTI_TICK_DIVIDER_PHASE_SYNC_EN is defined.
module divider_channel
  import multi_tick_divider_pkg::*;
#(
  parameter int               WIDTH       = DEF_WIDTH,
  parameter logic [WIDTH-1:0] DEFAULT_DIV = WIDTH'(DEF_DIV),
  parameter bit               RESET_EN    = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_tick,
  input  logic             i_wr,
  input  logic [WIDTH-1:0] i_wr_div,
  input  logic             i_wr_en,
`ifdef MULTI_TICK_DIVIDER_PHASE_SYNC_EN
  input  logic             i_sync,
`endif
  output logic             o_tick,
  output logic             o_sq
);

  logic [WIDTH-1:0] r_cnt;
  logic [WIDTH-1:0] r_div;
  logic             r_en;
  logic             r_tick;
  logic             r_sq;
  logic             w_terminal;

  // r_cnt stays below r_div, so r_div-1 never underflows when the channel is active.
  assign w_terminal = (r_cnt == (r_div - WIDTH'(1)));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt  <= '0;
      r_div  <= DEFAULT_DIV;
      r_en   <= RESET_EN;
      r_tick <= 1'b0;
      r_sq   <= 1'b0;
    end else begin
      r_tick <= 1'b0;
`ifdef MULTI_TICK_DIVIDER_PHASE_SYNC_EN
      if (i_sync) begin
        r_cnt <= '0;
        r_sq  <= 1'b0;
        if (i_wr) begin
          r_div <= i_wr_div;
          r_en  <= i_wr_en;
        end
      end else
`endif
      if (i_wr) begin
        r_div <= i_wr_div;
        r_en  <= i_wr_en;
        r_cnt <= '0;
        if (!i_wr_en) r_sq <= 1'b0;
      end else if (!r_en || (r_div == '0)) begin
        r_cnt <= '0;
        r_sq  <= 1'b0;
      end else if (i_tick) begin
        if (w_terminal) begin
          r_cnt  <= '0;
          r_tick <= 1'b1;
          r_sq   <= ~r_sq;
        end else begin
          r_cnt <= r_cnt + WIDTH'(1);
        end
      end
    end
  end

  assign o_tick = r_tick;
  assign o_sq   = r_sq;

endmodule

// File: rtl/multi_tick_divider.sv
// rtl/multi_tick_divider.sv - N-channel programmable tick divider with per-channel pulse and square outputs
// Defining MULTI_TICK_DIVIDER_PHASE_SYNC_EN adds sync_in, a global phase clear for all channels.
module multi_tick_divider
  import multi_tick_divider_pkg::*;
#(
  parameter int CHANNELS    = DEF_CHANNELS,
  parameter int WIDTH       = DEF_WIDTH,
  parameter int DEFAULT_DIV = DEF_DIV,
  parameter bit RESET_EN    = 1'b1
) (
  input  logic                             clk,
  input  logic                             reset,
`ifdef MULTI_TICK_DIVIDER_PHASE_SYNC_EN
  input  logic                             sync_in,
`endif
  input  logic                             tick_in,
  input  logic                             cfg_we,
  input  logic [idx_width(CHANNELS)-1:0]   cfg_ch,
  input  logic [WIDTH-1:0]                 cfg_div,
  input  logic                             cfg_en,
  output logic [CHANNELS-1:0]              tick_out,
  output logic [CHANNELS-1:0]              sq_out
);

  if (CHANNELS < 1 || WIDTH < 1 || (64'(DEFAULT_DIV) >> WIDTH) != 64'd0) begin : g_bad_params
    $fatal(1, "multi_tick_divider: invalid CHANNELS/WIDTH/DEFAULT_DIV");
  end

  logic [CHANNELS-1:0] w_wr;

  // Out-of-range channel indices match no generated channel and are dropped.
  for (genvar c = 0; c < CHANNELS; c++) begin : g_ch
    assign w_wr[c] = cfg_we && (int'(cfg_ch) == c);

    divider_channel #(
      .WIDTH       (WIDTH),
      .DEFAULT_DIV (WIDTH'(DEFAULT_DIV)),
      .RESET_EN    (RESET_EN)
    ) u_ch (
      .clk      (clk),
      .rst      (reset),
      .i_tick   (tick_in),
      .i_wr     (w_wr[c]),
      .i_wr_div (cfg_div),
      .i_wr_en  (cfg_en),
`ifdef MULTI_TICK_DIVIDER_PHASE_SYNC_EN
      .i_sync   (sync_in),
`endif
      .o_tick   (tick_out[c]),
      .o_sq     (sq_out[c])
    );
  end

endmodule

// File: tb/tb_multi_tick_divider.sv
// tb/tb_multi_tick_divider.sv - randomized model-checked bench for multi_tick_divider (4- and 3-channel builds)
module tb_multi_tick_divider;

  localparam int W  = 8;
  localparam int DD = 3;

  logic         clk = 1'b0;
  logic         reset;
  logic         sync_in;
  logic         tick_in;
  logic         cfg_we;
  logic [1:0]   cfg_ch;
  logic [W-1:0] cfg_div;
  logic         cfg_en;
  logic [3:0]   tick_a, sq_a;
  logic [2:0]   tick_b, sq_b;

  int checks   = 0;
  int failures = 0;
  bit chk_en   = 1'b0;

  always #5 clk = ~clk;

  multi_tick_divider #(.CHANNELS(4), .WIDTH(W), .DEFAULT_DIV(DD), .RESET_EN(1'b1)) u_a (
    .clk(clk), .reset(reset),
`ifdef MULTI_TICK_DIVIDER_PHASE_SYNC_EN
    .sync_in(sync_in),
`endif
    .tick_in(tick_in), .cfg_we(cfg_we), .cfg_ch(cfg_ch), .cfg_div(cfg_div),
    .cfg_en(cfg_en), .tick_out(tick_a), .sq_out(sq_a)
  );

  multi_tick_divider #(.CHANNELS(3), .WIDTH(W), .DEFAULT_DIV(DD), .RESET_EN(1'b1)) u_b (
    .clk(clk), .reset(reset),
`ifdef MULTI_TICK_DIVIDER_PHASE_SYNC_EN
    .sync_in(sync_in),
`endif
    .tick_in(tick_in), .cfg_we(cfg_we), .cfg_ch(cfg_ch), .cfg_div(cfg_div),
    .cfg_en(cfg_en), .tick_out(tick_b), .sq_out(sq_b)
  );

  // Model: n = ticks counted since the phase was last cleared; a pulse lands on every
  // multiple of div, and the square wave is a base level xor the parity of n/div.
  int         nch [2] = '{4, 3};
  int         mn  [2][4];
  int         mdv [2][4];
  bit         men [2][4];
  bit         msqb[2][4];
  logic [3:0] et  [2];
  logic [3:0] es  [2];

  function automatic bit cur_sq(input int m, input int c);
    if (men[m][c] && mdv[m][c] != 0) return msqb[m][c] ^ bit'((mn[m][c] / mdv[m][c]) % 2);
    return msqb[m][c];
  endfunction

  initial begin
    for (int m = 0; m < 2; m++) begin
      et[m] = '0;
      es[m] = '0;
    end
    forever begin
      @(posedge clk or posedge reset);
      for (int m = 0; m < 2; m++) begin
        for (int c = 0; c < 4; c++) begin
          bit wr;
          bit cs;
          wr = cfg_we && (int'(cfg_ch) == c) && (c < nch[m]);
          cs = cur_sq(m, c);
          et[m][c] = 1'b0;
          if (reset) begin
            mn[m][c] = 0; mdv[m][c] = DD; men[m][c] = 1'b1; msqb[m][c] = 1'b0;
          end else if (sync_in) begin
            mn[m][c] = 0; msqb[m][c] = 1'b0;
            if (wr) begin mdv[m][c] = int'(cfg_div); men[m][c] = cfg_en; end
          end else if (wr) begin
            mdv[m][c] = int'(cfg_div); men[m][c] = cfg_en; mn[m][c] = 0;
            msqb[m][c] = cfg_en ? cs : 1'b0;
          end else if (!men[m][c] || mdv[m][c] == 0) begin
            mn[m][c] = 0; msqb[m][c] = 1'b0;
          end else if (tick_in) begin
            mn[m][c]++;
            et[m][c] = (mn[m][c] % mdv[m][c]) == 0;
          end
          es[m][c] = cur_sq(m, c);
        end
      end
    end
  end

  task automatic chk(input string name, input logic [3:0] act, input logic [3:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s t=%0t actual=%b expected=%b", name, $time, act, exp);
    end
  endtask

  initial begin
    forever begin
      @(negedge clk);
      if (chk_en) begin
        chk("a_tick", tick_a, et[0]);
        chk("a_sq", sq_a, es[0]);
        chk("b_tick", {1'b0, tick_b}, {1'b0, et[1][2:0]});
        chk("b_sq", {1'b0, sq_b}, {1'b0, es[1][2:0]});
      end
    end
  end

  task automatic cyc(input bit t, input bit we = 1'b0, input logic [1:0] ch = 2'd0,
                     input logic [W-1:0] dv = '0, input bit en = 1'b1, input bit s = 1'b0);
    tick_in = t; cfg_we = we; cfg_ch = ch; cfg_div = dv; cfg_en = en; sync_in = s;
    @(negedge clk);
  endtask

  initial begin
    int ticks, pulses, k, found, found1;
    bit sq0, ch3_seen;
    reset = 1'b1; tick_in = 0; cfg_we = 0; cfg_ch = 0; cfg_div = 0; cfg_en = 0; sync_in = 0;
    repeat (2) @(negedge clk);
    chk_en = 1'b1;
    chk("reset_tick", tick_a, 4'h0);
    chk("reset_sq", sq_a, 4'h0);
    reset = 1'b0;

    // Default divide-by-3 with a tick every clk: pulse after edges 3,6; sq high after 3..5.
    for (int i = 1; i <= 7; i++) begin
      cyc(1'b1);
      chk("lit_div3_tick", tick_a, (i % 3 == 0) ? 4'hF : 4'h0);
      chk("lit_div3_sq", sq_a, (i >= 3 && i <= 5) ? 4'hF : 4'h0);
    end

    cyc(1'b0, 1'b1, 2'd1, W'(5), 1'b1);
    cyc(1'b0, 1'b1, 2'd2, W'(1), 1'b1);
    cyc(1'b0, 1'b1, 2'd3, W'(3), 1'b0);
    ticks = 0; pulses = 0; ch3_seen = 1'b0;
    for (int i = 0; i < 40; i++) begin
      cyc(i[0]);
      if (i[0]) ticks++;
      if (tick_a[2]) pulses++;
      if (tick_a[3] || sq_a[3]) ch3_seen = 1'b1;
    end
    chk("lit_div1_pulses", pulses[3:0], ticks[3:0]);
    chk("lit_ch3_idle", {3'b0, ch3_seen}, 4'h0);

    // Reprogram ch0 at counter=2 on a tick cycle: that tick is dropped, sq level holds.
    cyc(1'b0, 1'b1, 2'd0, W'(3), 1'b1);
    cyc(1'b1);
    cyc(1'b1);
    sq0 = sq_a[0];
    cyc(1'b1, 1'b1, 2'd0, W'(4), 1'b1);
    chk("lit_wr_sq_hold", {3'b0, sq_a[0]}, {3'b0, sq0});
    found = 0;
    for (k = 1; k <= 12 && found == 0; k++) begin
      cyc(1'b1);
      if (tick_a[0]) found = k;
    end
    chk("lit_div4_after_wr", found[3:0], 4'd4);

    cyc(1'b0, 1'b1, 2'd1, W'(0), 1'b1);
    cyc(1'b0, 1'b1, 2'd3, W'(1), 1'b1);
    for (int i = 0; i < 10; i++) cyc(1'b1);
    chk("lit_div0_idle", {2'b0, tick_a[1], sq_a[1]}, 4'h0);

    for (int i = 0; i < 400; i++) begin
      bit s;
`ifdef MULTI_TICK_DIVIDER_PHASE_SYNC_EN
      s = ($urandom % 16) == 0;
`else
      s = 1'b0;
`endif
      cyc(1'($urandom % 2), ($urandom % 8) == 0, 2'($urandom % 4),
          W'($urandom % 8), ($urandom % 4) != 0, s);
    end

    for (int c = 0; c < 4; c++) cyc(1'b0, 1'b1, 2'(c), W'(5), 1'b1);
    repeat (7) cyc(1'b1);
    tick_in = 1'b1;
    @(posedge clk);
    #2 reset = 1'b1;
    #1;
    chk("async_rst_tick_a", tick_a, 4'h0);
    chk("async_rst_sq_a", sq_a, 4'h0);
    chk("async_rst_b", {1'b0, tick_b | sq_b}, 4'h0);
    @(negedge clk);
    reset = 1'b0;
    found = 0;
    for (k = 1; k <= 10 && found == 0; k++) begin
      cyc(1'b1);
      if (tick_a[0]) found = k;
    end
    chk("lit_after_reset_div3", found[3:0], 4'd3);

`ifdef MULTI_TICK_DIVIDER_PHASE_SYNC_EN
    cyc(1'b0, 1'b1, 2'd0, W'(3), 1'b1);
    cyc(1'b1);
    cyc(1'b0, 1'b1, 2'd1, W'(4), 1'b1);
    repeat (5) cyc(1'b1);
    cyc(1'b1, 1'b0, 2'd0, '0, 1'b1, 1'b1);
    chk("lit_sync_clear", {2'b0, sq_a[1], sq_a[0]}, 4'h0);
    found = 0; found1 = 0;
    for (k = 1; k <= 10; k++) begin
      cyc(1'b1);
      if (tick_a[0] && found == 0) found = k;
      if (tick_a[1] && found1 == 0) found1 = k;
    end
    chk("lit_sync_ch0", found[3:0], 4'd3);
    chk("lit_sync_ch1", found1[3:0], 4'd4);
`else
    found1 = 0;
`endif

    repeat (3) cyc(1'b0);
    chk_en = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout t=%0t", $time);
    $fatal(1, "timeout");
  end

endmodule
